// File: rtl/led_pkg.sv
// Shared mode encodings and PWM width for the LED pattern generator.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_ON      = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_BREATHE = 2'b11
   } led_mode_e;

   localparam int PWM_W = 8;

endpackage

// File: rtl/led_channel.sv
// One LED channel: latched mode, blink phase, optional breathe duty/dir, LED register.
// Breathe logic exists only when LED_BREATHE_EN is defined; otherwise mode 11 blinks.
module led_channel
   import led_pkg::*;
#(
   parameter int BLINK_SH = 7
)(
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic [1:0]       i_mode,
   input  logic             i_tick,
`ifdef LED_BREATHE_EN
   input  logic [PWM_W-1:0] i_pwm_cnt,
`endif
   output logic             o_led
);

   led_mode_e             w_mode;
   led_mode_e             r_mode_q;
   logic [BLINK_SH-1:0]   r_ph;
   logic                  r_b;
   logic                  r_led;
   logic                  w_change;
   logic                  w_b_mode;
   logic                  w_led_next;

   assign w_mode   = led_mode_e'(i_mode);
   assign w_change = (w_mode != r_mode_q);

`ifdef LED_BREATHE_EN
   assign w_b_mode = (r_mode_q == MODE_BLINK);
`else
   assign w_b_mode = r_mode_q[1];
`endif

   // A mode change wins over a coincident tick: the tick is simply dropped.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_mode_q <= MODE_OFF;
         r_ph     <= '0;
         r_b      <= 1'b0;
      end else if (w_change) begin
         r_mode_q <= w_mode;
         r_ph     <= '0;
         r_b      <= 1'b0;
      end else if (i_tick && r_mode_q[1]) begin
         r_ph <= r_ph + BLINK_SH'(1);
         if ((r_ph == '1) && w_b_mode)
            r_b <= ~r_b;
      end
   end

`ifdef LED_BREATHE_EN
   logic [PWM_W-1:0] r_duty;
   logic             r_dir_up;

   always_ff @(posedge i_clk) begin
      if (!i_rstn || w_change) begin
         r_duty   <= '0;
         r_dir_up <= 1'b1;
      end else if (i_tick && (r_mode_q == MODE_BREATHE)) begin
         if (r_dir_up) begin
            if (r_duty == '1) begin
               r_duty   <= r_duty - PWM_W'(1);
               r_dir_up <= 1'b0;
            end else begin
               r_duty <= r_duty + PWM_W'(1);
            end
         end else begin
            if (r_duty == '0) begin
               r_duty   <= r_duty + PWM_W'(1);
               r_dir_up <= 1'b1;
            end else begin
               r_duty <= r_duty - PWM_W'(1);
            end
         end
      end
   end
`endif

   always_comb begin
      w_led_next = 1'b0;
      case (r_mode_q)
         MODE_OFF:     w_led_next = 1'b0;
         MODE_ON:      w_led_next = 1'b1;
         MODE_BLINK:   w_led_next = r_b;
`ifdef LED_BREATHE_EN
         MODE_BREATHE: w_led_next = (i_pwm_cnt < r_duty);
`else
         MODE_BREATHE: w_led_next = r_b;
`endif
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) r_led <= 1'b0;
      else         r_led <= w_led_next;
   end

   assign o_led = r_led;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler/PWM counter, N_CH led_channel instances.
// Define LED_BREATHE_EN to build the breathe (PWM) mode; otherwise mode 11 acts as blink.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int PRESC_W  = 16,
   parameter int BLINK_SH = 7
)(
   input  logic              CLK,
   input  logic              RSTN,
   input  logic [2*N_CH-1:0] MODE,
   output logic [N_CH-1:0]   LED,
   output logic              TICK
);

   logic [PRESC_W-1:0] r_presc;
   logic               r_tick;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
      end else begin
         r_presc <= r_presc + PRESC_W'(1);
         r_tick  <= (r_presc == '1);
      end
   end

`ifdef LED_BREATHE_EN
   logic [PWM_W-1:0] r_pwm_cnt;

   always_ff @(posedge CLK) begin
      if (!RSTN) r_pwm_cnt <= '0;
      else       r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
   end
`endif

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      led_channel #(
         .BLINK_SH (BLINK_SH)
      ) u_ch (
         .i_clk     (CLK),
         .i_rstn    (RSTN),
         .i_mode    (MODE[2*g +: 2]),
         .i_tick    (r_tick),
`ifdef LED_BREATHE_EN
         .i_pwm_cnt (r_pwm_cnt),
`endif
         .o_led     (LED[g])
      );
   end

   assign TICK = r_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (PRESC_W=2, BLINK_SH=1); honours LED_BREATHE_EN.
module tb_led_pattern_gen;

   localparam int          N_CH     = 4;
   localparam int          PRESC_W  = 2;
   localparam int          BLINK_SH = 1;
   localparam int unsigned P        = 1 << PRESC_W;
   localparam int          HMAX     = 64;

   logic              CLK = 1'b0;
   logic              RSTN;
   logic [2*N_CH-1:0] MODE;
   logic [N_CH-1:0]   LED;
   logic              TICK;

   led_pattern_gen #(
      .N_CH     (N_CH),
      .PRESC_W  (PRESC_W),
      .BLINK_SH (BLINK_SH)
   ) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .MODE (MODE),
      .LED  (LED),
      .TICK (TICK)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [N_CH-1:0] led;
      logic            tick;
      int unsigned     cyc;
      string           name;
   } exp_t;

   exp_t        q[$];
   int          checks   = 0;
   int          failures = 0;
   int unsigned k        = 0;
   int unsigned cyc_no   = 0;

   // Mode history per channel: mode h_mode[i] is in force from state k >= h_edge[i].
   int unsigned h_edge [N_CH][HMAX];
   logic [1:0]  h_mode [N_CH][HMAX];
   int unsigned h_n    [N_CH];

   function automatic int unsigned ticks_upto(input int unsigned s);
      return (s >= 1) ? (s - 1) / P : 0;
   endfunction

   // LED value derived from the state after edge s (closed form in tick count).
   function automatic logic ch_out(input int ch, input int unsigned s);
      int unsigned idx;
      int unsigned n;
      int unsigned p;
      int unsigned duty;
      logic [1:0]  md;
      idx = h_n[ch] - 1;
      while (idx > 0 && h_edge[ch][idx] > s) idx--;
      md = h_mode[ch][idx];
      n  = ticks_upto(s) - ticks_upto(h_edge[ch][idx]);
      p  = n % 510;
      duty = (p <= 255) ? p : 510 - p;
      case (md)
         2'b00:   return 1'b0;
         2'b01:   return 1'b1;
         2'b10:   return 1'((n >> BLINK_SH) & 1);
`ifdef LED_BREATHE_EN
         default: return ((s % 256) < duty);
`else
         default: return 1'((n >> BLINK_SH) & 1);
`endif
      endcase
   endfunction

   task automatic cyc(input logic rstn, input logic [2*N_CH-1:0] mode, input string name);
      exp_t       e;
      logic [1:0] md;
      @(negedge CLK);
      RSTN = rstn;
      MODE = mode;
      cyc_no++;
      e.name = name;
      e.cyc  = cyc_no;
      if (!rstn) begin
         e.led  = '0;
         e.tick = 1'b0;
         k      = 0;
         for (int ch = 0; ch < N_CH; ch++) begin
            h_n[ch]       = 1;
            h_edge[ch][0] = 0;
            h_mode[ch][0] = 2'b00;
         end
      end else begin
         k++;
         for (int ch = 0; ch < N_CH; ch++) begin
            e.led[ch] = ch_out(ch, k - 1);
            md = mode[2*ch +: 2];
            if (md != h_mode[ch][h_n[ch]-1] && h_n[ch] < HMAX) begin
               h_edge[ch][h_n[ch]] = k;
               h_mode[ch][h_n[ch]] = md;
               h_n[ch]++;
            end
         end
         e.tick = (k % P == 0);
      end
      q.push_back(e);
   endtask

   task automatic run(input int n, input logic [2*N_CH-1:0] mode, input string name);
      for (int i = 0; i < n; i++) cyc(1'b1, mode, name);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (LED !== e.led || TICK !== e.tick) begin
               failures++;
               $display("FAIL %s cycle=%0d LED=%b TICK=%b required LED=%b TICK=%b",
                        e.name, e.cyc, LED, TICK, e.led, e.tick);
            end
         end
      end
   end

   initial begin : stimulus
      RSTN = 1'b0;
      MODE = 8'h55;

      // Reset with all channels on, then release and free-run the prescaler.
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h55, "reset_all_on");
      run(6,  8'h55, "release_all_on");
      run(20, 8'h55, "tick_free_run");

      // Channel 0 blink: 8 low / 8 high.
      for (int i = 0; i < 2; i++) cyc(1'b0, 8'h02, "reset_blink");
      run(40, 8'h02, "blink_ch0");

      // blink -> on -> blink, last change landing on a TICK cycle.
      while (k % P != P - 1) cyc(1'b1, 8'h02, "blink_align");
      cyc(1'b1, 8'h01, "chg_to_on");
      cyc(1'b1, 8'h02, "chg_blink_on_tick");
      run(24, 8'h02, "blink_after_chg");

      // Mixed: ch3 breathe, ch2 blink, ch1 off, ch0 on; long enough for dir reversal.
      for (int i = 0; i < 2; i++) cyc(1'b0, 8'hE1, "reset_mixed");
      run(1100, 8'hE1, "mixed");

      // Mid-pattern reset must leave no residual phase.
      cyc(1'b0, 8'hE1, "mid_reset");
      run(40, 8'hE1, "after_mid_reset");

      @(posedge CLK);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
